// File: rtl/serial_adder_if.sv
// Handshake and data bundle between a requester and the bit-serial adder.
// The requester drives start/a/b; the adder returns status, sum and carry.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;

    modport master (
        output start, a, b,
        input  ready, busy, done, s, c
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, s, c
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: two half-adder cells plus an OR form one full-adder
// slice, with the carry registered between bits; LSB-first over WIDTH cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Half-adder cell: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-2:0] ps_r;
    logic             cy_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_r;
    logic             c_r;

    logic [1:0]       ha1_s;
    logic [1:0]       ha2_s;
    logic             sum_bit_s;
    logic             carry_nxt_s;
    logic [WIDTH-1:0] ps_nxt_s;
    logic             last_bit_s;

    // Full-adder slice on the current operand LSBs and the registered carry.
    always_comb begin
        ha1_s       = half_add(a_sh_r[0], b_sh_r[0]);
        ha2_s       = half_add(ha1_s[0], cy_r);
        sum_bit_s   = ha2_s[0];
        carry_nxt_s = ha1_s[1] | ha2_s[1];
        // The new sum bit enters at the MSB; ps_nxt_s is the full partial sum.
        ps_nxt_s    = {sum_bit_s, ps_r};
        last_bit_s  = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Control FSM with datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            ps_r    <= {(WIDTH-1){1'b0}};
            cy_r    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            s_r     <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh_r  <= bus.a;
                        b_sh_r  <= bus.b;
                        ps_r    <= {(WIDTH-1){1'b0}};
                        cy_r    <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    ps_r   <= ps_nxt_s[WIDTH-1:1];
                    cy_r   <= carry_nxt_s;
                    if (last_bit_s) begin
                        s_r     <= ps_nxt_s;
                        c_r     <= carry_nxt_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.s     = s_r;
    assign bus.c     = c_r;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  bus8();
    serial_adder_if #(.WIDTH(16)) bus16();

    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    typedef struct {
        logic [63:0] sum;
        int          acc;
    } exp_t;

    exp_t sb8[$];
    exp_t sb16[$];

    int   checks_cnt = 0;
    int   errors_cnt = 0;
    int   cyc = 0;
    int   acc8 = 0, acc16 = 0, dn8 = 0, dn16 = 0;
    logic prev_done8 = 1'b0, prev_done16 = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Completion monitors: pop the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus8.done === 1'b1) begin
            dn8++;
            check("done8_width", 64'(prev_done8), 64'd0);
            if (sb8.size() == 0) begin
                check("done8_unexpected", 64'(dn8), 64'(acc8));
            end else begin
                e = sb8.pop_front();
                check("sum8", 64'({bus8.c, bus8.s}), e.sum);
                check("lat8", 64'(cyc - e.acc), 64'd8);
            end
        end
        prev_done8 = bus8.done;
        if (bus16.done === 1'b1) begin
            dn16++;
            check("done16_width", 64'(prev_done16), 64'd0);
            if (sb16.size() == 0) begin
                check("done16_unexpected", 64'(dn16), 64'(acc16));
            end else begin
                e = sb16.pop_front();
                check("sum16", 64'({bus16.c, bus16.s}), e.sum);
                check("lat16", 64'(cyc - e.acc), 64'd16);
            end
        end
        prev_done16 = bus16.done;
    end

    task automatic add8(input logic [7:0] a, input logic [7:0] b);
        int   t = 0;
        exp_t e;
        while (bus8.ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready8_wait", 64'(bus8.ready), 64'd1);
        bus8.a     = a;
        bus8.b     = b;
        bus8.start = 1'b1;
        e.sum = 64'(a) + 64'(b);
        e.acc = cyc + 1;
        sb8.push_back(e);
        acc8++;
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic add16(input logic [15:0] a, input logic [15:0] b);
        int   t = 0;
        exp_t e;
        while (bus16.ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready16_wait", 64'(bus16.ready), 64'd1);
        bus16.a     = a;
        bus16.b     = b;
        bus16.start = 1'b1;
        e.sum = 64'(a) + 64'(b);
        e.acc = cyc + 1;
        sb16.push_back(e);
        acc16++;
        @(negedge clk);
        bus16.start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb8.size() != 0 || sb16.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain8", 64'(sb8.size()), 64'd0);
        check("drain16", 64'(sb16.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   prev_acc;
        int   dn_before;
        exp_t e;
        rst_n       = 1'b0;
        bus8.start  = 1'b0;
        bus8.a      = 8'h00;
        bus8.b      = 8'h00;
        bus16.start = 1'b0;
        bus16.a     = 16'h0000;
        bus16.b     = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state held through idle cycles.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle8", 64'({bus8.ready, bus8.busy, bus8.done, bus8.c, bus8.s}), 64'h800);
        end

        add8(8'hFF, 8'h01);
        add8(8'hA5, 8'h5A);
        add8(8'hC8, 8'h64);
        add8(8'h00, 8'h00);
        add8(8'h01, 8'h01);
        drain();

        // start held high: accepts only from IDLE, every WIDTH+2 cycles.
        @(negedge clk);
        bus8.a     = 8'h0F;
        bus8.b     = 8'h01;
        bus8.start = 1'b1;
        prev_acc   = -1;
        for (int i = 0; i < 35; i++) begin
            if (bus8.ready === 1'b1) begin
                e.sum = 64'h10;
                e.acc = cyc + 1;
                sb8.push_back(e);
                acc8++;
                if (prev_acc >= 0) check("b2b_gap", 64'(cyc + 1 - prev_acc), 64'd10);
                prev_acc = cyc + 1;
            end
            @(negedge clk);
        end
        bus8.start = 1'b0;
        drain();

        // Abort mid-operation with reset at E4.
        add8(8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        rst_n     = 1'b0;
        dn_before = dn8;
        @(negedge clk);
        check("abort_state", 64'({bus8.ready, bus8.busy, bus8.done, bus8.c, bus8.s}), 64'h800);
        sb8.delete();
        acc8--;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", 64'(dn8), 64'(dn_before));
        check("abort_hold", 64'({bus8.c, bus8.s}), 64'h0);
        add8(8'h03, 8'h04);
        drain();

        fork
            begin
                for (int i = 0; i < 1000; i++) add8(8'($urandom), 8'($urandom));
            end
            begin
                for (int j = 0; j < 1000; j++) add16(16'($urandom), 16'($urandom));
            end
        join
        drain();
        check("done_cnt8", 64'(dn8), 64'(acc8));
        check("done_cnt16", 64'(dn16), 64'(acc16));

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
